// File: rtl/speed_pkg.sv
// Shared types and defaults for the multi-channel speed detector.
// Optional glitch filtering is selected with the GLITCH_FILTER_EN macro.
package speed_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned CLK_HZ          = 40000000;
    localparam int unsigned DEF_GATE_CYCLES = CLK_HZ;
    localparam int unsigned DEF_OUT_W       = 8;

    // Width of a counter that must reach cycles-1; never narrower than 1 bit.
    function automatic int unsigned gate_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/speed_channel.sv
// One tach channel: synchroniser, optional stability filter (GLITCH_FILTER_EN),
// rising-edge detect, saturating edge counter and latched result.
module speed_channel #(
    parameter int unsigned OUT_W         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic             clear,
    input  logic             latch,
    output logic [OUT_W-1:0] speed,
    output logic             sat
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   level;
    logic                   prev;
    logic                   rise;
    logic [OUT_W:0]         cnt;
    logic [OUT_W:0]         cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pulse};
        end
    end

    assign sync_out = sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);

    logic          filt;
    logic [FW-1:0] fcnt;

    // Filtered level follows only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (filt != sync_out) begin
            if (fcnt == FW'(FILTER_CYCLES - 1)) begin
                filt <= sync_out;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end else begin
            fcnt <= '0;
        end
    end

    assign level = filt;
`else
    assign level = sync_out;
`endif

    assign rise     = level & ~prev;
    assign cnt_next = (rise && !cnt[OUT_W]) ? cnt + (OUT_W+1)'(1) : cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev  <= 1'b0;
            cnt   <= '0;
            speed <= '0;
            sat   <= 1'b0;
        end else begin
            prev <= level;
            if (clear) begin
                cnt <= '0;
            end else if (latch) begin
                // The window-end cycle's own edge is folded into the published result.
                cnt   <= '0;
                speed <= cnt_next[OUT_W] ? '1 : cnt_next[OUT_W-1:0];
                sat   <= cnt_next[OUT_W];
            end else begin
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/multi_speed_detector.sv
// Multi-channel tach speed detector: common gate window, per-channel counts,
// one-cycle valid strobe. GLITCH_FILTER_EN enables per-channel input filtering.
module multi_speed_detector
    import speed_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned OUT_W         = DEF_OUT_W,
    parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS*OUT_W-1:0] speed,
    output logic [CHANNELS-1:0]       sat,
    output logic                      valid
);

    localparam int unsigned GW = gate_w(GATE_CYCLES);

    state_t        state;
    logic [GW-1:0] gate;
    logic          window_end;
    logic          clear;
    logic          latch;

    assign window_end = (state == RUN) && (gate == GW'(GATE_CYCLES - 1));
    assign clear      = (state == IDLE) || !enable;
    assign latch      = window_end && enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gate  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate <= '0;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        gate  <= '0;
                    end else if (window_end) begin
                        gate  <= '0;
                        valid <= 1'b1;
                    end else begin
                        gate <= gate + GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gate  <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        speed_channel #(
            .OUT_W        (OUT_W),
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .pulse (pulse[i]),
            .clear (clear),
            .latch (latch),
            .speed (speed[i*OUT_W +: OUT_W]),
            .sat   (sat[i])
        );
    end

endmodule

// File: tb/tb_multi_speed_detector.sv
// Randomised scoreboard bench: a waveform-level reference model predicts every
// window result (edge count, saturation, strobe time) from the applied pin samples.
module tb_multi_speed_detector;

    localparam int CH   = 4;
    localparam int W    = 4;
    localparam int G    = 200;
    localparam int SS   = 2;
    localparam int FC   = 4;
`ifdef GLITCH_FILTER_EN
    localparam int D    = SS + 1;
`else
    localparam int D    = SS;
`endif
    localparam int HIST = D + 2;
    localparam int SATV = 1 << W;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [CH-1:0]     pulse;
    logic [CH*W-1:0]   speed;
    logic [CH-1:0]     sat;
    logic              valid;

    multi_speed_detector #(
        .CHANNELS     (CH),
        .OUT_W        (W),
        .GATE_CYCLES  (G),
        .SYNC_STAGES  (SS),
        .FILTER_CYCLES(FC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .pulse (pulse),
        .speed (speed),
        .sat   (sat),
        .valid (valid)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no++;

    typedef struct {
        int              edge_n;
        logic [CH*W-1:0] spd;
        logic [CH-1:0]   st;
    } exp_t;

    exp_t sbq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state
    bit              run = 0;
    int              wstart = 0;
    int              acc[CH];
    bit              hist[CH][HIST];
    bit              q[CH];
    int              qrun[CH];
    logic [CH*W-1:0] last_spd = '0;
    logic [CH-1:0]   last_sat = '0;

    // Stimulus generator state
    int mode[CH];
    int per[CH];
    int ph[CH];
    int glen[CH];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic gen_pin(input int c, output bit v);
        if (glen[c] > 0) begin
            glen[c]--;
            v = 1'b1;
            return;
        end
        case (mode[c])
            0:       v = 1'b0;
            1:       v = 1'b1;
            default: begin
                ph[c] = (ph[c] + 1) % per[c];
                v = (ph[c] < per[c] / 2);
            end
        endcase
        if (!v && mode[c] != 1 && $urandom_range(0, 39) == 0) begin
            glen[c] = $urandom_range(0, 2);
            v = 1'b1;
        end
    endtask

    // Window rule: after enable is seen at edge wstart, windows close at
    // wstart+G, wstart+2G, ...; a pin rise sampled at edge k counts at edge k+D.
    task automatic model_edge(input int n, input bit en, input bit rst_n);
        bit s, l;
        bit rise[CH];
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            s = rst_n ? pulse[c] : 1'b0;
`ifdef GLITCH_FILTER_EN
            if (!rst_n) begin
                q[c] = 1'b0;
                qrun[c] = 0;
            end else if (s != q[c]) begin
                qrun[c]++;
                if (qrun[c] == FC) begin
                    q[c] = s;
                    qrun[c] = 0;
                end
            end else begin
                qrun[c] = 0;
            end
            l = q[c];
`else
            l = s;
`endif
            for (int j = HIST - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = l;
            rise[c] = hist[c][D] & ~hist[c][D+1];
        end
        if (!rst_n) begin
            run = 0;
            last_spd = '0;
            last_sat = '0;
            sbq.delete();
            return;
        end
        if (!run) begin
            if (en) begin
                run = 1;
                wstart = n;
                for (int c = 0; c < CH; c++) acc[c] = 0;
            end
        end else if (!en) begin
            run = 0;
        end else begin
            for (int c = 0; c < CH; c++)
                if (rise[c] && acc[c] < SATV) acc[c]++;
            if ((n - wstart) % G == 0) begin
                e.edge_n = n;
                for (int c = 0; c < CH; c++) begin
                    e.spd[c*W +: W] = (acc[c] >= SATV) ? {W{1'b1}} : W'(acc[c]);
                    e.st[c] = (acc[c] >= SATV);
                    acc[c] = 0;
                end
                sbq.push_back(e);
                last_spd = e.spd;
                last_sat = e.st;
            end
        end
    endtask

    task automatic step(input bit en, input bit rst_n);
        int n;
        bit v;
        @(negedge clk);
        n = edge_no + 1;
        for (int c = 0; c < CH; c++) begin
            gen_pin(c, v);
            pulse[c] = v;
        end
        enable = en;
        reset  = rst_n;
        model_edge(n, en, rst_n);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, including its edge time.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1 && valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 64'(valid), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("valid_edge", 64'(edge_no), 64'(e.edge_n));
                    chk("speed", 64'(speed), 64'(e.spd));
                    chk("sat", 64'(sat), 64'(e.st));
                end
            end
        end
    end

    initial begin
        int len;
        reset  = 1'b0;
        enable = 1'b0;
        pulse  = '0;
        for (int c = 0; c < CH; c++) begin
            acc[c] = 0; q[c] = 0; qrun[c] = 0; glen[c] = 0; ph[c] = 0;
            mode[c] = 2; per[c] = 10 + 10 * c;
            for (int j = 0; j < HIST; j++) hist[c][j] = 0;
        end

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        #1;
        chk("reset_speed", 64'(speed), 64'(0));
        chk("reset_sat", 64'(sat), 64'(0));
        chk("reset_valid", 64'(valid), 64'(0));

        for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);
        #1;
        chk("idle_speed", 64'(speed), 64'(0));
        chk("idle_sat", 64'(sat), 64'(0));

        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < CH; c++) begin
                mode[c] = $urandom_range(0, 3);
                per[c]  = $urandom_range(6, 60);
                ph[c]   = 0;
            end
            if (p == 0) begin
                // ch0 saturates (20 edges/window), ch2 constant high, ch3 low
                mode[0] = 2; per[0] = 10;
                mode[1] = 2; per[1] = 40;
                mode[2] = 1;
                mode[3] = 0;
            end
            len = G * $urandom_range(2, 4) + $urandom_range(0, G - 1);
            for (int i = 0; i < len; i++) step(1'b1, 1'b1);
            case (p % 3)
                0: begin
                    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
                    #1;
                    chk("hold_speed", 64'(speed), 64'(last_spd));
                    chk("hold_sat", 64'(sat), 64'(last_sat));
                end
                1: begin
                    step(1'b1, 1'b0);
                    #1;
                    chk("async_rst_speed", 64'(speed), 64'(0));
                    chk("async_rst_sat", 64'(sat), 64'(0));
                    chk("async_rst_valid", 64'(valid), 64'(0));
                    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
                end
                default: ;
            endcase
        end

        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        #1;
        chk("pending_results", 64'(sbq.size()), 64'(0));
        chk("final_hold_speed", 64'(speed), 64'(last_spd));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
